// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / interlock unit.
//   FWD_RF        : select value meaning "take the operand from the register file"
//   REG_BITS_DEF  : default register-address width
//   REG_BITS_MAX  : widest register address an entry can hold (addresses are zero-extended)
//   entry_t       : one tracked writer stage {valid, regwrite, load, rd}
package hazard_pkg;

   localparam int REG_BITS_DEF = 5;
   localparam int REG_BITS_MAX = 8;
   localparam int FWD_RF       = 0;

   typedef struct packed {
      logic                    valid;
      logic                    regwrite;
      logic                    load;
      logic [REG_BITS_MAX-1:0] rd;
   } entry_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// EX-side bus of the forwarding / interlock unit.
//   master : the EX stage, which drives instruction fields and fwd_enable and
//            receives the operand selects, stall and stall counter.
//   slave  : the hazard unit itself.
interface fwd_hazard_unit_if
   import hazard_pkg::*;
#(
   parameter int REG_BITS = REG_BITS_DEF,
   parameter int DEPTH    = 2
);
   localparam int SELW = $clog2(DEPTH + 1);

   logic                ex_valid;
   logic                ex_regwrite;
   logic                ex_load;
   logic [REG_BITS-1:0] ex_rd;
   logic [REG_BITS-1:0] ex_rs1;
   logic [REG_BITS-1:0] ex_rs2;
   logic                ex_use_rs1;
   logic                ex_use_rs2;
   logic                fwd_enable;
   logic [SELW-1:0]     fwd_rs1_sel;
   logic [SELW-1:0]     fwd_rs2_sel;
   logic                stall;
   logic [15:0]         stall_cycles;

   modport master (
      output ex_valid, ex_regwrite, ex_load, ex_rd, ex_rs1, ex_rs2,
             ex_use_rs1, ex_use_rs2, fwd_enable,
      input  fwd_rs1_sel, fwd_rs2_sel, stall, stall_cycles
   );

   modport slave (
      input  ex_valid, ex_regwrite, ex_load, ex_rd, ex_rs1, ex_rs2,
             ex_use_rs1, ex_use_rs2, fwd_enable,
      output fwd_rs1_sel, fwd_rs2_sel, stall, stall_cycles
   );

endinterface

// File: rtl/fwd_hazard_unit_stage_match.sv
// Compares one tracked writer stage against one EX source operand.
//   ent      : tracked entry of stage STAGE
//   rs       : zero-extended EX source register
//   rs_used  : EX instruction actually reads this source
//   ex_valid : EX holds a real instruction
//   match    : this stage writes the register the operand reads
//   ready    : the stage's result can be forwarded now
module fwd_stage_match
   import hazard_pkg::*;
#(
   parameter int STAGE      = 1,
   parameter int LOAD_READY = 2
) (
   input  entry_t                  ent,
   input  logic [REG_BITS_MAX-1:0] rs,
   input  logic                    rs_used,
   input  logic                    ex_valid,
   output logic                    match,
   output logic                    ready
);

   // Load data exists from stage LOAD_READY onward; everything else is ready at once.
   localparam logic LATE = (STAGE >= LOAD_READY);

   assign match = ent.valid & ent.regwrite & (ent.rd == rs) & (ent.rd != '0)
                & rs_used & ex_valid;
   assign ready = ~ent.load | LATE;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and interlock unit for the integer pipeline.
// Tracks DEPTH writer stages after EX, picks the youngest matching producer per
// EX operand, and stalls ID/EX while that producer's value is not yet usable.
//   clk   : pipeline clock
//   rst_n : asynchronous active-low reset
//   bus   : EX-side bus (instruction fields in; operand selects, stall, counter out)
module fwd_hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_BITS   = REG_BITS_DEF,
   parameter int DEPTH      = 2,
   parameter int LOAD_READY = 2,
   parameter int SELW       = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   fwd_hazard_unit_if.slave  bus
);

   entry_t            ent [1:DEPTH];
   entry_t            ent_new;
   logic [DEPTH:1]    m1, r1, m2, r2;
   logic [SELW:0]     pick1, pick2;
   logic              stall;
   logic [15:0]       stall_cnt;

   logic [REG_BITS_MAX-1:0] rs1_ext, rs2_ext;

   assign rs1_ext = REG_BITS_MAX'(bus.ex_rs1);
   assign rs2_ext = REG_BITS_MAX'(bus.ex_rs2);

   for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
      fwd_stage_match #(.STAGE(k), .LOAD_READY(LOAD_READY)) u_rs1 (
         .ent(ent[k]), .rs(rs1_ext), .rs_used(bus.ex_use_rs1), .ex_valid(bus.ex_valid),
         .match(m1[k]), .ready(r1[k])
      );
      fwd_stage_match #(.STAGE(k), .LOAD_READY(LOAD_READY)) u_rs2 (
         .ent(ent[k]), .rs(rs2_ext), .rs_used(bus.ex_use_rs2), .ex_valid(bus.ex_valid),
         .match(m2[k]), .ready(r2[k])
      );
   end

   // Returns {stall, sel}. Scanning oldest to youngest lets the youngest match
   // overwrite any older one, so older producers never influence the result.
   // With forwarding off, any match holds the operand on the register file.
   function automatic logic [SELW:0] pick(input logic [DEPTH:1] m,
                                          input logic [DEPTH:1] r,
                                          input logic           en);
      logic [SELW:0] res;
      res = {1'b0, SELW'(FWD_RF)};
      for (int k = DEPTH; k >= 1; k--) begin
         if (m[k]) res = (en && r[k]) ? {1'b0, SELW'(k)} : {1'b1, SELW'(FWD_RF)};
      end
      return res;
   endfunction

   assign pick1 = pick(m1, r1, bus.fwd_enable);
   assign pick2 = pick(m2, r2, bus.fwd_enable);
   assign stall = pick1[SELW] | pick2[SELW];

   assign bus.fwd_rs1_sel  = pick1[SELW-1:0];
   assign bus.fwd_rs2_sel  = pick2[SELW-1:0];
   assign bus.stall        = stall;
   assign bus.stall_cycles = stall_cnt;

   // A stalled or empty EX slot enters the tracker as a bubble.
   always_comb begin
      ent_new          = '0;
      ent_new.valid    = bus.ex_valid & ~stall;
      ent_new.regwrite = bus.ex_regwrite;
      ent_new.load     = bus.ex_load;
      ent_new.rd       = REG_BITS_MAX'(bus.ex_rd);
   end

   // Tracker advances every clock; a stall only inserts a bubble at stage 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k <= DEPTH; k++) ent[k] <= '0;
         stall_cnt <= '0;
      end else begin
         ent[1] <= ent_new;
         for (int k = 2; k <= DEPTH; k++) ent[k] <= ent[k-1];
         if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: drives the same EX stream into a DEPTH=2/LOAD_READY=2
// unit (a) and a DEPTH=3/LOAD_READY=3 unit (b), checks both against an
// instruction-history model every cycle, and pins key points with literal values.
module tb_fwd_hazard_unit;

   typedef struct {
      bit valid;
      bit rw;
      bit load;
      int rd;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ex_valid = 0, ex_regwrite = 0, ex_load = 0;
   logic [4:0] ex_rd = 0, ex_rs1 = 0, ex_rs2 = 0;
   logic       ex_use_rs1 = 0, ex_use_rs2 = 0;
   logic       fwd_enable = 1;

   int checks = 0;
   int failures = 0;

   rec_t hist_a [1:3];
   rec_t hist_b [1:3];
   int   cnt_a = 0, cnt_b = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit_if #(.REG_BITS(5), .DEPTH(2)) ifa ();
   fwd_hazard_unit_if #(.REG_BITS(5), .DEPTH(3)) ifb ();

   assign ifa.ex_valid = ex_valid;     assign ifb.ex_valid = ex_valid;
   assign ifa.ex_regwrite = ex_regwrite; assign ifb.ex_regwrite = ex_regwrite;
   assign ifa.ex_load = ex_load;       assign ifb.ex_load = ex_load;
   assign ifa.ex_rd = ex_rd;           assign ifb.ex_rd = ex_rd;
   assign ifa.ex_rs1 = ex_rs1;         assign ifb.ex_rs1 = ex_rs1;
   assign ifa.ex_rs2 = ex_rs2;         assign ifb.ex_rs2 = ex_rs2;
   assign ifa.ex_use_rs1 = ex_use_rs1; assign ifb.ex_use_rs1 = ex_use_rs1;
   assign ifa.ex_use_rs2 = ex_use_rs2; assign ifb.ex_use_rs2 = ex_use_rs2;
   assign ifa.fwd_enable = fwd_enable; assign ifb.fwd_enable = fwd_enable;

   fwd_hazard_unit #(.REG_BITS(5), .DEPTH(2), .LOAD_READY(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
   );
   fwd_hazard_unit #(.REG_BITS(5), .DEPTH(3), .LOAD_READY(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // One operand against the history: the most recently issued writer of the
   // register decides; it is usable if forwarding is on and its value exists.
   function automatic void model_op(input rec_t h [1:3], input int depth, input int lr,
                                    input bit en, input bit used, input int rs,
                                    output int sel, output bit st);
      sel = 0;
      st  = 0;
      if (!(ex_valid && used) || rs == 0) return;
      for (int k = 1; k <= depth; k++) begin
         if (h[k].valid && h[k].rw && h[k].rd == rs) begin
            if (en && (!h[k].load || k >= lr)) sel = k;
            else st = 1;
            return;
         end
      end
   endfunction

   function automatic void model(input rec_t h [1:3], input int depth, input int lr,
                                 output int s1, output int s2, output bit st);
      bit st1, st2;
      model_op(h, depth, lr, fwd_enable, ex_use_rs1, int'(ex_rs1), s1, st1);
      model_op(h, depth, lr, fwd_enable, ex_use_rs2, int'(ex_rs2), s2, st2);
      st = st1 | st2;
   endfunction

   // History update: what leaves EX at each edge, bubble if stalled or empty.
   always @(posedge clk or negedge rst_n) begin
      int s1, s2;
      bit st;
      if (!rst_n) begin
         for (int k = 1; k <= 3; k++) begin
            hist_a[k] = '{default: 0};
            hist_b[k] = '{default: 0};
         end
         cnt_a = 0;
         cnt_b = 0;
      end else begin
         model(hist_a, 2, 2, s1, s2, st);
         if (st && cnt_a != 65535) cnt_a++;
         hist_a[3] = hist_a[2];
         hist_a[2] = hist_a[1];
         hist_a[1] = '{valid: ex_valid & ~st, rw: ex_regwrite, load: ex_load, rd: int'(ex_rd)};
         model(hist_b, 3, 3, s1, s2, st);
         if (st && cnt_b != 65535) cnt_b++;
         hist_b[3] = hist_b[2];
         hist_b[2] = hist_b[1];
         hist_b[1] = '{valid: ex_valid & ~st, rw: ex_regwrite, load: ex_load, rd: int'(ex_rd)};
      end
   end

   always @(negedge clk) begin
      int s1, s2;
      bit st;
      model(hist_a, 2, 2, s1, s2, st);
      chk("cyc_a_sel1", int'(ifa.fwd_rs1_sel), s1);
      chk("cyc_a_sel2", int'(ifa.fwd_rs2_sel), s2);
      chk("cyc_a_stall", int'(ifa.stall), int'(st));
      chk("cyc_a_cnt", int'(ifa.stall_cycles), cnt_a);
      model(hist_b, 3, 3, s1, s2, st);
      chk("cyc_b_sel1", int'(ifb.fwd_rs1_sel), s1);
      chk("cyc_b_sel2", int'(ifb.fwd_rs2_sel), s2);
      chk("cyc_b_stall", int'(ifb.stall), int'(st));
      chk("cyc_b_cnt", int'(ifb.stall_cycles), cnt_b);
   end

   task automatic step(input bit v, input bit rw, input bit ld, input int rd,
                       input int rs1, input bit u1, input int rs2, input bit u2);
      @(posedge clk);
      #1;
      ex_valid = v;  ex_regwrite = rw; ex_load = ld; ex_rd = 5'(rd);
      ex_rs1 = 5'(rs1); ex_use_rs1 = u1; ex_rs2 = 5'(rs2); ex_use_rs2 = u2;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #3;
      chk("rst_a_stall", int'(ifa.stall), 0);
      chk("rst_a_sel1", int'(ifa.fwd_rs1_sel), 0);
      chk("rst_a_cnt", int'(ifa.stall_cycles), 0);
      #19 rst_n = 1'b1;

      // 1: ADD r3 then two consumers of r3
      step(1, 1, 0, 3, 1, 1, 2, 1);
      step(1, 0, 0, 0, 3, 1, 0, 0);
      chk("s1_a_sel1_k1", int'(ifa.fwd_rs1_sel), 1);
      chk("s1_a_stall", int'(ifa.stall), 0);
      chk("s1_b_sel1_k1", int'(ifb.fwd_rs1_sel), 1);
      step(1, 0, 0, 0, 3, 1, 0, 0);
      chk("s1_a_sel1_k2", int'(ifa.fwd_rs1_sel), 2);
      idle(3);

      // 2: two writers of r3, R-type consumer reads r3 on rs2
      step(1, 1, 0, 3, 0, 0, 0, 0);
      step(1, 1, 0, 3, 0, 0, 0, 0);
      step(1, 1, 0, 7, 1, 1, 3, 1);
      chk("s2_a_sel2_young", int'(ifa.fwd_rs2_sel), 1);
      chk("s2_a_sel1", int'(ifa.fwd_rs1_sel), 0);
      idle(3);

      // 3: LW r4 then held consumer of r4
      step(1, 1, 1, 4, 1, 1, 0, 0);
      step(1, 0, 0, 0, 4, 1, 0, 0);
      chk("s3_a_stall_c1", int'(ifa.stall), 1);
      chk("s3_a_sel_c1", int'(ifa.fwd_rs1_sel), 0);
      chk("s3_b_stall_c1", int'(ifb.stall), 1);
      step(1, 0, 0, 0, 4, 1, 0, 0);
      chk("s3_a_stall_c2", int'(ifa.stall), 0);
      chk("s3_a_sel_c2", int'(ifa.fwd_rs1_sel), 2);
      chk("s3_b_stall_c2", int'(ifb.stall), 1);
      step(1, 0, 0, 0, 4, 1, 0, 0);
      chk("s3_b_sel_c3", int'(ifb.fwd_rs1_sel), 3);
      chk("s3_b_stall_c3", int'(ifb.stall), 0);
      chk("s3_a_cnt", int'(ifa.stall_cycles), 1);
      chk("s3_b_cnt", int'(ifb.stall_cycles), 2);
      idle(3);

      // 4: r0 never forwards; a non-register jump reads nothing
      step(1, 1, 0, 0, 1, 1, 2, 1);
      step(1, 0, 0, 0, 0, 1, 0, 1);
      chk("s4_a_r0_sel", int'(ifa.fwd_rs1_sel), 0);
      chk("s4_a_r0_stall", int'(ifa.stall), 0);
      step(1, 1, 0, 5, 1, 1, 2, 1);
      step(1, 1, 0, 1, 5, 0, 5, 0);
      chk("s4_a_jmp_sel1", int'(ifa.fwd_rs1_sel), 0);
      chk("s4_a_jmp_stall", int'(ifa.stall), 0);
      idle(3);

      // 5: interlock mode, counters cleared first
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      fwd_enable = 1'b0;
      step(1, 1, 0, 5, 1, 1, 2, 1);
      step(1, 0, 0, 0, 5, 1, 0, 0);
      chk("s5_a_stall_c1", int'(ifa.stall), 1);
      step(1, 0, 0, 0, 5, 1, 0, 0);
      chk("s5_a_stall_c2", int'(ifa.stall), 1);
      step(1, 0, 0, 0, 5, 1, 0, 0);
      chk("s5_a_stall_c3", int'(ifa.stall), 0);
      chk("s5_a_sel_c3", int'(ifa.fwd_rs1_sel), 0);
      chk("s5_a_cnt", int'(ifa.stall_cycles), 2);
      chk("s5_b_stall_c3", int'(ifb.stall), 1);
      step(1, 0, 0, 0, 5, 1, 0, 0);
      chk("s5_b_stall_c4", int'(ifb.stall), 0);
      chk("s5_b_cnt", int'(ifb.stall_cycles), 3);
      chk("s5_a_cnt_hold", int'(ifa.stall_cycles), 2);
      fwd_enable = 1'b1;
      idle(3);

      // 6: async reset in the middle of a load-use stall
      step(1, 1, 1, 4, 1, 1, 0, 0);
      step(1, 0, 0, 0, 4, 1, 0, 0);
      chk("s6_a_stall_pre", int'(ifa.stall), 1);
      rst_n = 1'b0;
      #1;
      chk("s6_a_stall_rst", int'(ifa.stall), 0);
      chk("s6_a_cnt_rst", int'(ifa.stall_cycles), 0);
      chk("s6_b_stall_rst", int'(ifb.stall), 0);
      chk("s6_b_cnt_rst", int'(ifb.stall_cycles), 0);
      #1 rst_n = 1'b1;
      step(1, 0, 0, 0, 4, 1, 0, 0);
      chk("s6_a_sel_after", int'(ifa.fwd_rs1_sel), 0);
      chk("s6_a_stall_after", int'(ifa.stall), 0);
      idle(3);

      // 7: ex_valid dropping removes the stall and creates no entry
      step(1, 1, 1, 6, 1, 1, 0, 0);
      step(0, 0, 0, 0, 6, 1, 0, 0);
      chk("s7_a_stall_novalid", int'(ifa.stall), 0);
      step(1, 0, 0, 0, 6, 1, 0, 0);
      chk("s7_a_sel_k2", int'(ifa.fwd_rs1_sel), 2);
      chk("s7_b_stall_k2", int'(ifb.stall), 1);
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

- Parametrised forwarding and interlock unit for the integer pipeline; it generalises the single-stage WB-to-EX hazard check to DEPTH tracked writer stages.
- Tracks the destination register of every in-flight instruction past EX in an internal shift register.
- For each EX operand, selects the youngest ready producer.
- Generates a multi-cycle stall when the youngest producer is a load whose data is not yet available. With forwarding disabled, it interlocks until the producer has reached the register file.

## Interface
Parameters:
- REG_BITS, 5, register-address width
- DEPTH, 2, tracked writer stages after EX (1 = MEM … DEPTH = last stage before RF write visible)
- LOAD_READY, 2, lowest stage index at which load data is forwardable (1 ≤ LOAD_READY ≤ DEPTH)
- SELW, $clog2(DEPTH+1), forward-select width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX holds a real instruction
- ex_regwrite  in  1  EX instruction writes rd
- ex_load  in  1  EX instruction is a load
- ex_rd  in  REG_BITS  EX destination
- ex_rs1, ex_rs2  in  REG_BITS  EX sources
- ex_use_rs1, ex_use_rs2  in  1  source actually read (decoder sets use_rs2 for R-type and store data; clears both for non-register jumps)
- fwd_enable  in  1  1 = forwarding, 0 = pure interlock
- fwd_rs1_sel, fwd_rs2_sel  out  SELW  0 = RF value, k = forward from stage k
- stall  out  1  freeze ID/EX this cycle
- stall_cycles  out  16  saturating count of stalled cycles

## Operation
- Entry k (1..DEPTH) holds {valid, regwrite, load, rd}.
- A stage k matches operand s when all of these hold: valid_k, regwrite_k, rd_k == ex_rs_s, rd_k != 0, and ex_use_s & ex_valid.
- Register 0 never forwards and never stalls.
- Youngest match (smallest k) is authoritative; older matches are ignored even if ready.
- Forwarding mode, youngest match at k:
  - ready when not load_k, or k ≥ LOAD_READY → sel = k;
  - otherwise sel = 0 and stall for this operand.
- Interlock mode, any match in any stage → sel = 0 and stall.
- stall = OR of both operand stall terms.
- sel and stall are combinational from the current entries and EX inputs.
- Advance, every clock: entry k+1 ← entry k.
  - Entry 1 ← EX fields when ex_valid & ~stall.
  - Entry 1 ← bubble (valid = 0) otherwise.
  - Entries never freeze; a stall only inserts a bubble.
- stall_cycles increments on each clock with stall = 1 and saturates at 16'hFFFF.

## Timing
- Reset (async, on rst_n low):
  - all entries invalid;
  - fwd_rs*_sel = 0, stall = 0, stall_cycles = 0, immediately, mid-stall included.
- Zero-latency select: sel and stall are valid in the same cycle as the EX inputs.
- Tracking latency: an instruction in EX at edge t occupies stage k during cycle t+k.
- Load-use stall length, forwarding mode: LOAD_READY − k cycles for a load found at stage k, then sel = LOAD_READY.
- Interlock stall length: DEPTH − k + 1 cycles, then sel = 0.
  - RF is written at the end of stage DEPTH, so the value is visible to EX once the producer has left stage DEPTH.
- Simultaneous rs1/rs2 stalls merge; the stall length is the maximum of the two.
- ex_valid falling while stalled: stall drops combinationally, and no entry is created.
- A producer in EX that is itself the consumer (same instruction): no self-match, since EX is not a tracked stage.
- fwd_enable changing mid-stall: takes effect the same cycle.

## Structure
- Package hazard_pkg:
  - FWD_RF = 0 select constant;
  - default REG_BITS;
  - the entry struct {valid, regwrite, load, rd}.
- One sub-module, fwd_stage_match, instantiated DEPTH×2: computes match and ready for one stage against one operand.
- The top-level priority encoder, shift register and counter live in fwd_hazard_unit.

## Test plan
All scenarios use DEPTH=2, LOAD_READY=2 unless stated.
1. Cycle 0 EX: ADD r3 (regwrite). Cycle 1 EX: rs1 = r3, use_rs1 = 1 → fwd_rs1_sel = 1, stall = 0. Cycle 2, another consumer of r3 → sel = 2.
2. Two writers of r3 back to back, then consumer using r3 as rs2 (R-type) → fwd_rs2_sel = 1, not 2.
3. LW r4, then consumer of r4:
   - cycle 1: stall = 1, sel = 0;
   - cycle 2: stall = 0, fwd_rs1_sel = 2;
   - stall_cycles = 1.
   - Repeat with DEPTH = 3, LOAD_READY = 3 → 2 stall cycles, then sel = 3.
4. ADD r0, then consumer of r0 → sel = 0, stall = 0. Non-register jump (use_rs1 = use_rs2 = 0) after ADD r5 with rs1 = r5 → sel = 0.
5. fwd_enable = 0, ADD r5, then consumer of r5 → stall for 2 cycles, then sel = 0, stall = 0; stall_cycles = 2.
6. During a load-use stall, drop rst_n asynchronously between edges → stall and stall_cycles read 0 before the next clock edge; after release, the consumer proceeds with sel = 0.
